// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states,
// and a helper that tells which modes can be repeated as a burst.
// Imported by usr_shift_core and univ_shift_reg.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  // The encoding makes busy and done each equal to a single state flop bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Only the shift/rotate modes make sense when repeated N times.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Next-value logic for the shift register: one application of a mode to q.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is registered.
// Ports: q (current value), mode, d (load data), sin_l/sin_r (serial inputs)
//        -> q_next (value after one operation).
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD:  q_next = q;
      MODE_LOAD:  q_next = d;
      MODE_SHL:   q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLEAR: q_next = RESET_VAL;
      default:    q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with single ops and a repeated-shift burst engine.
// Latency: single ops take effect at the next enabled edge; a burst of N ends with done N+1 edges after acceptance.
// Backpressure: en=0 holds q in idle and stalls a burst (q and count frozen, busy stays high).
// Ports: clk, rst (async high), en, mode, d, sin_l, sin_r, start, nbits
//        -> q, sout_l/sout_r (q MSB/LSB), busy, done (one-cycle pulse).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CW-1:0]    nbits,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     mode_lat, mode_lat_nxt;
  logic [WIDTH-1:0] q_nxt, shift_q;
  logic [2:0]     core_mode;
  logic [CW-1:0]  burst_len;

  // During a burst the latched mode drives the core; live mode is ignored.
  assign core_mode = (state == BUSY) ? mode_lat : mode;

  // More shifts than bits would only repeat work, so the length saturates.
  assign burst_len = (nbits > WIDTH_C) ? WIDTH_C : nbits;

  usr_shift_core #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .q      (q),
    .mode   (core_mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (shift_q)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mode_lat_nxt = mode_lat;
    q_nxt        = q;
    case (state)
      IDLE: begin
        if (en) begin
          if (start && is_burst_mode(mode)) begin
            // Accepting edge only arms the burst; q is untouched here.
            mode_lat_nxt = mode;
            cnt_nxt      = burst_len;
            state_nxt    = (burst_len == '0) ? DONE : BUSY;
          end else begin
            q_nxt = shift_q;
          end
        end
      end
      BUSY: begin
        if (en) begin
          q_nxt   = shift_q;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RESET_VAL;
      state    <= IDLE;
      cnt      <= '0;
      mode_lat <= MODE_HOLD;
    end else begin
      q        <= q_nxt;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mode_lat <= mode_lat_nxt;
    end
  end

  assign busy   = (state == BUSY);
  assign done   = (state == DONE);
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] nbits;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  univ_shift_reg dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .nbits  (nbits),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] pre;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; start = 1'b0; mode = MODE_LOAD; d = v;
    tick();
    mode = MODE_HOLD;
  endtask

  task automatic check_state(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    check({name, ".q"}, {24'd0, q}, {24'd0, eq});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, eb});
    check({name, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  initial begin
    vecs[0] = '{"load", 8'hA5, MODE_LOAD,  8'h3C, 1'b0, 1'b0, 8'h3C};
    vecs[1] = '{"shl0", 8'hA5, MODE_SHL,   8'hFF, 1'b0, 1'b0, 8'h4A};
    vecs[2] = '{"shl1", 8'hA5, MODE_SHL,   8'hFF, 1'b0, 1'b1, 8'h4B};
    vecs[3] = '{"shr0", 8'hA5, MODE_SHR,   8'hFF, 1'b0, 1'b0, 8'h52};
    vecs[4] = '{"shr1", 8'hA5, MODE_SHR,   8'hFF, 1'b1, 1'b0, 8'hD2};
    vecs[5] = '{"rol",  8'hA5, MODE_ROL,   8'hFF, 1'b0, 1'b0, 8'h4B};
    vecs[6] = '{"ror",  8'hA5, MODE_ROR,   8'hFF, 1'b0, 1'b0, 8'hD2};
    vecs[7] = '{"asr",  8'hA5, MODE_ASR,   8'hFF, 1'b0, 1'b0, 8'hD2};
    vecs[8] = '{"asrp", 8'h5A, MODE_ASR,   8'hFF, 1'b1, 1'b1, 8'h2D};
    vecs[9] = '{"clr",  8'hA5, MODE_CLEAR, 8'hFF, 1'b1, 1'b1, 8'h00};

    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; nbits = 4'd0;
    tick(); tick();
    check_state("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle with no clock edge in between.
    load(8'h3C);
    check("pre_rst.q", {24'd0, q}, 32'h3C);
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0; en = 1'b0; mode = MODE_LOAD; d = 8'h77;
    tick(); tick();
    check("rst_hold.q", {24'd0, q}, 32'h00);

    // Load, then a disabled load must not change q.
    load(8'hA5);
    check("load.q", {24'd0, q}, 32'hA5);
    en = 1'b0; mode = MODE_LOAD; d = 8'hFF;
    tick(); tick(); tick();
    check("en0_hold.q", {24'd0, q}, 32'hA5);

    for (int i = 0; i < 10; i++) begin
      load(vecs[i].pre);
      mode = vecs[i].mode; d = vecs[i].d; sin_l = vecs[i].sl; sin_r = vecs[i].sr;
      tick();
      check({"vec_", vecs[i].name, ".q"}, {24'd0, q}, {24'd0, vecs[i].exp});
      check({"vec_", vecs[i].name, ".sout_l"}, {31'd0, sout_l}, {31'd0, vecs[i].exp[7]});
      check({"vec_", vecs[i].name, ".sout_r"}, {31'd0, sout_r}, {31'd0, vecs[i].exp[0]});
    end
    sin_l = 1'b0; sin_r = 1'b0; mode = MODE_HOLD;

    // Burst ROL x3 from 81, with a second start (and a LOAD mode) issued while busy.
    load(8'h81);
    start = 1'b1; mode = MODE_ROL; nbits = 4'd3;
    tick();
    check_state("b_accept", 8'h81, 1'b1, 1'b0);
    mode = MODE_LOAD; d = 8'h00; nbits = 4'd8;
    tick();
    check_state("b_1", 8'h03, 1'b1, 1'b0);
    tick();
    check_state("b_2", 8'h06, 1'b1, 1'b0);
    tick();
    check_state("b_3", 8'h0C, 1'b0, 1'b1);
    mode = MODE_ROL;
    tick();
    check_state("b_idle", 8'h0C, 1'b0, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    tick();
    check_state("b_idle2", 8'h0C, 1'b0, 1'b0);

    // Same burst with a two-cycle stall in the middle.
    load(8'h81);
    start = 1'b1; mode = MODE_ROL; nbits = 4'd3;
    tick();
    check_state("s_accept", 8'h81, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    tick();
    check_state("s_1", 8'h03, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    check_state("s_stall1", 8'h03, 1'b1, 1'b0);
    tick();
    check_state("s_stall2", 8'h03, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    check_state("s_2", 8'h06, 1'b1, 1'b0);
    tick();
    check_state("s_3", 8'h0C, 1'b0, 1'b1);
    tick();
    check_state("s_idle", 8'h0C, 1'b0, 1'b0);

    // Zero-length burst goes straight to done.
    load(8'hA5);
    start = 1'b1; mode = MODE_ROL; nbits = 4'd0;
    tick();
    check_state("z_done", 8'hA5, 1'b0, 1'b1);
    start = 1'b0; mode = MODE_HOLD;
    tick();
    check_state("z_idle", 8'hA5, 1'b0, 1'b0);

    // Over-long burst clamps to 8 rotations, returning to the start value.
    load(8'hA5);
    start = 1'b1; mode = MODE_ROL; nbits = 4'd12;
    tick();
    start = 1'b0; mode = MODE_HOLD;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 4) check("c_half.q", {24'd0, q}, 32'h5A);
    end
    check_state("c_7", 8'hD2, 1'b1, 1'b0);
    tick();
    check_state("c_done", 8'hA5, 1'b0, 1'b1);
    tick();
    check_state("c_idle", 8'hA5, 1'b0, 1'b0);

    // start with a non-burst mode is a plain single op.
    start = 1'b1; mode = MODE_LOAD; d = 8'h77;
    tick();
    check_state("nb_load", 8'h77, 1'b0, 1'b0);
    mode = MODE_CLEAR;
    tick();
    check_state("nb_clear", 8'h00, 1'b0, 1'b0);
    start = 1'b0; mode = MODE_HOLD;

    // Reset in the middle of a burst: no done pulse afterwards.
    load(8'h81);
    start = 1'b1; mode = MODE_ROL; nbits = 4'd5;
    tick();
    start = 1'b0; mode = MODE_HOLD;
    tick();
    check_state("r_1", 8'h03, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_state("r_async", 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_state("r_after1", 8'h00, 1'b0, 1'b0);
    tick();
    check_state("r_after2", 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
